// File: rtl/rv32_mod_lsu_split.sv
// RV32 load/store unit front end: drives one or two word-aligned bus beats per
// hart access, splitting misaligned halfword/word accesses across a word boundary.
module rv32_mod_lsu_split #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT          = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [3:0]  req_type,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid,
  output logic        error,
  output logic        stall,
  output logic        dext_req,
  output logic        dext_wr,
  input  logic        dext_ack,
  input  logic        dext_err,
  output logic [3:0]  dext_be,
  output logic [31:0] dext_addr,
  output logic [31:0] dext_do,
  input  logic [31:0] dext_di
);

  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [31:0]    addr_q, wdata_q, buf_q, buf_d, data_q, data_d;
  logic [1:0]     size_q;
  logic           uns_q, wr_q, err_q, err_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic        accept, req_illegal, in_beat, wd_expired, beat_fail, load_done, mis_q;
  logic [7:0]  cur_mask;
  logic [4:0]  sh;
  logic [31:0] ld_lo, ld_hi, ld_raw, ld_ext, rot_do;
  logic        unused_rsvd;

  function automatic logic is_mis(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b01 && off == 2'b11) || (size == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [7:0] mask8(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

  assign unused_rsvd = req_type[2];
  assign accept      = (state_q == S_IDLE) && req;
  assign req_illegal = (req_type[1:0] == 2'b11) ||
                       (!ALLOW_MISALIGNED && is_mis(req_type[1:0], address[1:0]));
  assign in_beat     = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign cur_mask    = mask8(size_q, addr_q[1:0]);
  assign mis_q       = |cur_mask[7:4];
  assign sh          = {addr_q[1:0], 3'b000};
  assign wd_expired  = (TIMEOUT != 0) && (wdog_q == WD_LAST);
  // An error response wins over a simultaneous ack.
  assign beat_fail   = in_beat && (dext_err || (!dext_ack && wd_expired));
  assign load_done   = in_beat && dext_ack && !dext_err && !wr_q &&
                       ((state_q == S_BEAT1) || !mis_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      buf_q   <= '0;
      wdog_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      wdog_q  <= wdog_d;
      data_q  <= data_d;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= data_i;
        size_q  <= req_type[1:0];
        uns_q   <= req_type[3];
        wr_q    <= wr;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = req_illegal ? S_RESP : S_BEAT0;
          err_d   = req_illegal;
        end
      end
      S_BEAT0: begin
        if (beat_fail) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else if (dext_ack) begin
          state_d = mis_q ? S_BEAT1 : S_RESP;
          err_d   = 1'b0;
        end
      end
      S_BEAT1: begin
        if (beat_fail) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else if (dext_ack) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: watchdog restarts on every beat entry.
  always_comb begin
    wdog_d = '0;
    if (in_beat && state_d == state_q && TIMEOUT != 0) wdog_d = wdog_q + 1'b1;
    buf_d  = (state_q == S_BEAT0 && dext_ack && !dext_err) ? dext_di : buf_q;
    ld_lo  = (state_q == S_BEAT1) ? buf_q : dext_di;
    ld_hi  = (state_q == S_BEAT1) ? dext_di : 32'h0;
    ld_raw = 32'({ld_hi, ld_lo} >> sh);
    case (size_q)
      2'b00:   ld_ext = {{24{!uns_q && ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_ext = {{16{!uns_q && ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
    data_d = load_done ? ld_ext : data_q;
    rot_do = (wdata_q << sh) | (wdata_q >> (6'd32 - {1'b0, sh}));
  end

  always_comb begin
    dext_req  = in_beat;
    dext_wr   = in_beat && wr_q;
    dext_addr = 32'h0;
    dext_be   = 4'h0;
    dext_do   = in_beat ? rot_do : 32'h0;
    if (state_q == S_BEAT0) begin
      dext_addr = {addr_q[31:2], 2'b00};
      dext_be   = cur_mask[3:0];
    end else if (state_q == S_BEAT1) begin
      dext_addr = {addr_q[31:2] + 30'd1, 2'b00};
      dext_be   = cur_mask[7:4];
    end
    valid = (state_q == S_RESP) && !err_q;
    error = (state_q == S_RESP) && err_q;
    stall = accept || in_beat;
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_rv32_mod_lsu_split.sv
// Scoreboard bench for rv32_mod_lsu_split: a byte-lane bus model answers beats,
// expected completions are queued at issue and checked on each valid/error pulse.
module tb_rv32_mod_lsu_split;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n, req, req_b, wr, dext_ack, dext_err;
  logic [3:0]  req_type;
  logic [31:0] address, data_i, dext_di;
  logic [31:0] data_o, dext_addr, dext_do;
  logic        valid, error, stall, dext_req, dext_wr;
  logic [3:0]  dext_be;
  logic [31:0] b_data_o, b_dext_addr, b_dext_do;
  logic        b_valid, b_error, b_stall, b_dext_req, b_dext_wr;
  logic [3:0]  b_dext_be;

  typedef struct { bit is_err; logic [31:0] data; } exp_t;
  exp_t        sb[$];
  logic [31:0] dout_m;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  rv32_mod_lsu_split #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_type(req_type), .wr(wr),
    .address(address), .data_i(data_i), .data_o(data_o), .valid(valid), .error(error),
    .stall(stall), .dext_req(dext_req), .dext_wr(dext_wr), .dext_ack(dext_ack),
    .dext_err(dext_err), .dext_be(dext_be), .dext_addr(dext_addr), .dext_do(dext_do),
    .dext_di(dext_di));

  rv32_mod_lsu_split #(.ALLOW_MISALIGNED(1'b0)) u_nomis (
    .clk(clk), .reset_n(reset_n), .req(req_b), .req_type(req_type), .wr(wr),
    .address(address), .data_i(data_i), .data_o(b_data_o), .valid(b_valid), .error(b_error),
    .stall(b_stall), .dext_req(b_dext_req), .dext_wr(b_dext_wr), .dext_ack(dext_ack),
    .dext_err(dext_err), .dext_be(b_dext_be), .dext_addr(b_dext_addr), .dext_do(b_dext_do),
    .dext_di(dext_di));

  function automatic logic [31:0] model_load(input logic [3:0] rt, input logic [31:0] a,
                                             input logic [31:0] di0, input logic [31:0] di1);
    int n, off, lane;
    logic [31:0] r;
    n = 1 << rt[1:0];
    off = int'(a[1:0]);
    r = '0;
    for (int i = 0; i < n; i++) begin
      lane = off + i;
      if (lane < 4) r[8*i +: 8] = di0[8*lane +: 8];
      else          r[8*i +: 8] = di1[8*(lane-4) +: 8];
    end
    if (n < 4 && !rt[3] && r[8*n-1])
      for (int i = 8*n; i < 32; i++) r[i] = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n && (valid || error)) begin
      tests++;
      if (valid && error) begin
        fails++;
        $display("FAIL excl: valid=%0b error=%0b, required one-hot", valid, error);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious_pulse: valid=%0b error=%0b, required no pulse", valid, error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (error !== e.is_err || data_o !== e.data) begin
          fails++;
          $display("FAIL completion: error=%0b data_o=%h, required error=%0b data_o=%h",
                   error, data_o, e.is_err, e.data);
        end
      end
    end
  end

  task automatic access(input bit w, input logic [3:0] rt, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] di0, input logic [31:0] di1,
                        input int wt, input bit err0);
    exp_t e;
    int n, off, beat, waited, cyc, reqc, exp_lat, exp_reqc, nbeats, lane;
    bit ill, mis, tmo, done;
    logic [3:0]  ebe [2];
    logic [31:0] eaddr [2];
    logic [31:0] edo;
    n = 1 << rt[1:0];
    off = int'(a[1:0]);
    ill = (rt[1:0] == 2'b11);
    mis = !ill && (off + n > 4);
    nbeats = mis ? 2 : 1;
    tmo = !ill && !err0 && (wt >= TO);
    eaddr[0] = {a[31:2], 2'b00};
    eaddr[1] = eaddr[0] + 32'd4;
    ebe[0] = '0;
    ebe[1] = '0;
    edo = '0;
    if (!ill)
      for (int i = 0; i < n; i++) begin
        lane = off + i;
        if (lane < 4) ebe[0][lane] = 1'b1;
        else          ebe[1][lane-4] = 1'b1;
      end
    for (int j = 0; j < 4; j++) edo[8*((j+off)%4) +: 8] = d[8*j +: 8];
    if (ill)       begin exp_lat = 1;      exp_reqc = 0;  end
    else if (err0) begin exp_lat = 2;      exp_reqc = 1;  end
    else if (tmo)  begin exp_lat = 1 + TO; exp_reqc = TO; end
    else begin
      exp_reqc = nbeats * (wt + 1);
      exp_lat  = 1 + exp_reqc;
    end
    e.is_err = ill || err0 || tmo;
    if (!e.is_err && !w) dout_m = model_load(rt, a, di0, di1);
    e.data = dout_m;
    sb.push_back(e);

    @(posedge clk); #1;
    req = 1'b1; wr = w; req_type = rt; address = a; data_i = d;
    beat = 0; waited = 0; cyc = 0; reqc = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      dext_ack = 1'b0;
      dext_err = 1'b0;
      if (dext_req) begin
        reqc++;
        if (waited == 0 && beat < 2) begin
          tests++;
          if (dext_addr !== eaddr[beat] || dext_be !== ebe[beat] ||
              dext_wr !== w || dext_do !== edo) begin
            fails++;
            $display("FAIL beat%0d @%h: addr=%h be=%b wr=%0b do=%h, required addr=%h be=%b wr=%0b do=%h",
                     beat, a, dext_addr, dext_be, dext_wr, dext_do, eaddr[beat], ebe[beat], w, edo);
          end
        end
        if (beat == 0 && err0) begin
          dext_ack = 1'b1; dext_err = 1'b1; beat++; waited = 0;
        end else if (waited >= wt) begin
          dext_ack = 1'b1; dext_di = (beat == 0) ? di0 : di1; beat++; waited = 0;
        end else waited++;
      end
      if (!stall) begin
        req = 1'b0;
        done = 1;
      end
    end
    dext_ack = 1'b0;
    dext_err = 1'b0;
    req = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL bound @%h: stall still high after %0d cycles, required completion", a, cyc);
    end else if (cyc - 1 != exp_lat || reqc != exp_reqc) begin
      fails++;
      $display("FAIL timing @%h: latency=%0d req_cycles=%0d, required latency=%0d req_cycles=%0d",
               a, cyc - 1, reqc, exp_lat, exp_reqc);
    end
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if (data_o !== 0 || valid !== 0 || error !== 0 || dext_req !== 0 || dext_be !== 0 ||
        dext_addr !== 0 || dext_do !== 0 || dext_wr !== 0) begin
      fails++;
      $display("FAIL reset_vals: data_o=%h v=%0b e=%0b req=%0b be=%b addr=%h do=%h, required all 0",
               data_o, valid, error, dext_req, dext_be, dext_addr, dext_do);
    end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (stall !== 0 || dext_req !== 0 || valid !== 0 || error !== 0) begin
      fails++;
      $display("FAIL idle_after_reset: stall=%0b req=%0b v=%0b e=%0b, required 0",
               stall, dext_req, valid, error);
    end
  endtask

  task automatic test_byte_loads;
    access(0, 4'b0000, 32'h103, 0, 32'h8000_0000, 0, 0, 0);
    tests++;
    if (data_o !== 32'hFFFF_FF80) begin
      fails++; $display("FAIL lb: data_o=%h, required ffffff80", data_o);
    end
    access(0, 4'b1000, 32'h103, 0, 32'h8000_0000, 0, 0, 0);
    tests++;
    if (data_o !== 32'h0000_0080) begin
      fails++; $display("FAIL lbu: data_o=%h, required 00000080", data_o);
    end
  endtask

  task automatic test_split;
    logic [31:0] keep;
    keep = data_o;
    access(1, 4'b0010, 32'h202, 32'h1122_3344, 0, 0, 0, 0);
    tests++;
    if (data_o !== keep) begin
      fails++; $display("FAIL sw_keeps_data: data_o=%h, required %h", data_o, keep);
    end
    access(0, 4'b0010, 32'hFFFF_FFFE, 0, 32'hAABB_0000, 32'h0000_CCDD, 0, 0);
    tests++;
    if (data_o !== 32'hCCDD_AABB) begin
      fails++; $display("FAIL lw_wrap: data_o=%h, required ccddaabb", data_o);
    end
    access(0, 4'b0001, 32'h7, 0, 32'h5600_0000, 32'h0000_0081, 1, 0);
  endtask

  task automatic test_errors;
    logic [31:0] keep;
    keep = data_o;
    access(0, 4'b0001, 32'h3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    access(0, 4'b0011, 32'h40, 0, 0, 0, 0, 0);
    access(0, 4'b0010, 32'h10, 0, 32'h1234_5678, 0, 10, 0);
    tests++;
    if (data_o !== keep) begin
      fails++; $display("FAIL err_keeps_data: data_o=%h, required %h", data_o, keep);
    end
  endtask

  task automatic test_back_to_back;
    access(0, 4'b0010, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, 0);
    access(1, 4'b0000, 32'h101, 32'h0000_00A5, 0, 0, 0, 0);
    access(0, 4'b1001, 32'h102, 0, 32'hF00D_0000, 0, 2, 0);
    access(0, 4'b0010, 32'h105, 0, 32'h0102_0304, 32'h0506_0708, 3, 0);
  endtask

  task automatic test_random;
    logic [3:0] rt;
    for (int k = 0; k < 24; k++) begin
      rt = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      if ($urandom_range(0, 11) == 0) rt[1:0] = 2'b11;
      access(1'($urandom_range(0, 1)), rt, $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
    end
  endtask

  task automatic test_no_misaligned;
    int nreq, nerr, nval;
    nreq = 0; nerr = 0; nval = 0;
    @(posedge clk); #1;
    req_b = 1'b1; wr = 1'b0; req_type = 4'b0010; address = 32'h1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b_dext_req) nreq++;
      if (b_error) nerr++;
      if (b_valid) nval++;
      if (!b_stall) req_b = 1'b0;
    end
    tests++;
    if (nreq != 0 || nerr != 1 || nval != 0) begin
      fails++;
      $display("FAIL nomis_reject: req_cycles=%0d errors=%0d valids=%0d, required 0/1/0",
               nreq, nerr, nval);
    end
    nval = 0;
    @(posedge clk); #1;
    req_b = 1'b1; address = 32'h8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      dext_ack = b_dext_req;
      dext_di = 32'h1234_5678;
      if (b_valid) nval++;
      if (!b_stall) req_b = 1'b0;
    end
    dext_ack = 1'b0;
    tests++;
    if (nval != 1 || b_data_o !== 32'h1234_5678) begin
      fails++;
      $display("FAIL nomis_aligned: valids=%0d data_o=%h, required 1 and 12345678", nval, b_data_o);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; req_type = 4'b0010; address = 32'h202; data_i = 32'h1122_3344;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!dext_req && c < 5);
    dext_ack = 1'b1;
    @(negedge clk);
    dext_ack = 1'b0;
    tests++;
    if (dext_req !== 1'b1 || dext_addr !== 32'h204) begin
      fails++;
      $display("FAIL mid_beat1: req=%0b addr=%h, required 1 and 00000204", dext_req, dext_addr);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if (dext_req !== 1'b0 || dext_be !== 4'h0 || data_o !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: req=%0b be=%b data_o=%h, required 0", dext_req, dext_be, data_o);
    end
    req = 1'b0;
    dout_m = '0;
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; req_b = 1'b0; wr = 1'b0; req_type = '0;
    address = '0; data_i = '0; dext_ack = 1'b0; dext_err = 1'b0; dext_di = '0;
    dout_m = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_byte_loads();
    test_split();
    test_errors();
    test_back_to_back();
    test_random();
    test_no_misaligned();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_completions: %0d outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
